// File: rtl/mult_pkg.sv
// Shared types and constants for the add/shift multiplier.
package mult_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam logic [2:0]  LAST_STEP = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        HOLD
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/subadder.sv
// 8-bit adder/subtractor with a 9-bit sign-extended result {x_s_o, s_o}.
// fn_i = 1 computes a_i - b_i, otherwise a_i + b_i.
module subadder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       fn_i,
    output logic [7:0] s_o,
    output logic       x_s_o
);

    logic [7:0] b_op;
    logic [8:0] sum;

    // Two's complement subtract: invert the operand and inject the carry-in.
    always_comb begin
        b_op  = b_i ^ {8{fn_i}};
        sum   = {a_i[7], a_i} + {b_op[7], b_op} + {8'd0, fn_i};
        s_o   = sum[7:0];
        x_s_o = sum[8];
    end

endmodule : subadder

// File: rtl/add_shift_multiplier.sv
// Sequential 8x8 signed multiplier using repeated add/subtract and arithmetic shift.
// Product ends up in {A,B} with X as the sign extension of A.
module add_shift_multiplier
    import mult_pkg::*;
#(
    // Only 8 is supported; the subadder datapath is fixed at 8 bits.
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             Load_B,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    mult_state_t state_q, state_d;
    logic        x_q, x_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  m_q, m_d;
    logic [2:0]  count_q, count_d;

    logic [7:0]  sum_s;
    logic        sum_x;
    logic        fn;

    // The final partial product carries the multiplier's sign weight, so it is subtracted.
    assign fn = (count_q == LAST_STEP);

    subadder u_subadder (
        .a_i   (a_q),
        .b_i   (m_q),
        .fn_i  (fn),
        .s_o   (sum_s),
        .x_s_o (sum_x)
    );

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                // Load_B wins over Run when both are high.
                if (Load_B) begin
                    b_d = SW;
                end else if (Run) begin
                    x_d     = 1'b0;
                    a_d     = 8'd0;
                    m_d     = SW;
                    count_d = 3'd0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    x_d = sum_x;
                    a_d = sum_s;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = {x_q, a_q[7:1]};
                b_d     = {a_q[0], b_q[7:1]};
                count_d = count_q + 3'd1;
                state_d = (count_q == LAST_STEP) ? HOLD : ADD;
            end
            HOLD: begin
                if (Load_B) begin
                    b_d = SW;
                end
                // Run held high keeps the result; it must drop before another start.
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All architectural state; reset aborts any operation in progress.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            m_q     <= 8'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from registers or the decoded state.
    always_comb begin
        Aval = a_q;
        Bval = b_q;
        Xval = x_q;
        Busy = (state_q == ADD) || (state_q == SHIFT);
        Done = (state_q == HOLD);
    end

endmodule : add_shift_multiplier

// File: tb/tb_add_shift_multiplier.sv
// Directed bench for add_shift_multiplier with a queue-based result scoreboard.
module tb_add_shift_multiplier;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Run = 1'b0;
    logic       Load_B = 1'b0;
    logic [7:0] SW = 8'd0;
    logic [7:0] Aval, Bval;
    logic       Xval, Busy, Done;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb_q[$];
    logic [7:0]  b_model = 8'd0;

    add_shift_multiplier #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Run     (Run),
        .Load_B  (Load_B),
        .SW      (SW),
        .Aval    (Aval),
        .Bval    (Bval),
        .Xval    (Xval),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v);
        Load_B = 1'b1;
        SW     = v;
        tick();
        Load_B  = 1'b0;
        b_model = v;
    endtask

    // Return to IDLE, then start; the expected product is queued at start time.
    task automatic start(input logic [7:0] sw, input bit keep_run);
        logic signed [15:0] prod;
        Run = 1'b0;
        tick();
        prod = $signed({{8{b_model[7]}}, b_model}) * $signed({{8{sw[7]}}, sw});
        sb_q.push_back({prod[15], prod});
        Run = 1'b1;
        SW  = sw;
        tick();
        if (!keep_run) Run = 1'b0;
    endtask

    // Wait (bounded) for Done, optionally disturbing SW/Load_B mid-run, then score.
    task automatic wait_done(input string tag, input int disturb_at);
        int n = 0;
        int busy_cnt = 0;
        logic [16:0] exp;
        while (!Done && n < 40) begin
            if (Busy) busy_cnt++;
            if (n == disturb_at) begin
                SW     = ~SW;
                Load_B = 1'b1;
            end
            tick();
            Load_B = 1'b0;
            n++;
        end
        check({tag, "_done"}, Done, 1);
        check({tag, "_latency"}, n, 16);
        check({tag, "_busy_cycles"}, busy_cnt, 16);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h1ffff;
        check({tag, "_xab"}, {Xval, Aval, Bval}, exp);
        b_model = exp[7:0];
    endtask

    initial begin
        logic [16:0] held;
        bit          moved;

        #1 Reset_n = 1'b0;
        #1;
        check("reset_xab", {Xval, Aval, Bval}, 0);
        check("reset_busy_done", {Busy, Done}, 0);
        #12 Reset_n = 1'b1;
        tick();

        // 7 * 59, then hold Run high past Done and confirm no restart.
        load_b(8'h3B);
        start(8'h07, 1'b1);
        wait_done("t1_pos", -1);
        held  = {Xval, Aval, Bval};
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!Done || Busy || ({Xval, Aval, Bval} !== held)) moved = 1'b1;
        end
        check("t6_no_restart", moved, 0);
        // Restart multiplies the previous low byte 0x9D by 2.
        start(8'h02, 1'b0);
        wait_done("t6_restart", -1);

        // -7 * 59
        load_b(8'h3B);
        start(8'hF9, 1'b0);
        wait_done("t2_neg_m", -1);

        // 7 * -59, then -128 * -128
        load_b(8'hC5);
        start(8'h07, 1'b0);
        wait_done("t3_neg_b", -1);
        load_b(8'h80);
        start(8'h80, 1'b0);
        wait_done("t3_min_min", -1);

        // SW toggle and Load_B mid-operation must be ignored.
        load_b(8'h3B);
        start(8'h07, 1'b0);
        wait_done("t4_disturb", 5);

        // Asynchronous reset in the middle of an operation.
        load_b(8'h3B);
        start(8'h07, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_busy_before_rst", Busy, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("t5_rst_xab", {Xval, Aval, Bval}, 0);
        check("t5_rst_busy_done", {Busy, Done}, 0);
        void'(sb_q.pop_front());
        b_model = 8'd0;
        tick();
        #2 Reset_n = 1'b1;
        tick();
        tick();
        check("t5_idle_after", {Busy, Done}, 0);

        // Recovery run after reset.
        load_b(8'hD3);
        start(8'h5A, 1'b0);
        wait_done("t5_recover", -1);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add_shift_multiplier
